spd_ramp: RTL and testbench
===========================

# spd_ramp

Slew-rate limiter and sign-to-magnitude stage feeding the motor driver. It accepts signed per-wheel speed targets and ramps a commanded speed toward each target by a fixed step once per PWM frame. Each commanded speed is emitted as an 11-bit magnitude plus a reverse flag, which map directly onto the driver's `lft_spd`/`lft_rev`/`rght_spd`/`rght_rev` inputs. An optional zero-speed dwell enforces a rest period before any wheel reverses direction.

## Interface
- `STEP`, default 16: magnitude change per update tick; 1..2047.
- `UPD_PERIOD`, default 2048: clocks between update ticks; matches the 11-bit PWM frame; ≥2.
- `DWELL_FRAMES`, default 4: ticks held at zero before a reversal; 1..255.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `lft_tgt`, in, 12: left target speed, signed two's complement.
- `rght_tgt`, in, 12: right target speed, signed two's complement.
- `tgt_vld`, in, 1: capture both targets on this clock; always accepted, no ready.
- `lft_spd`, out, 11: left magnitude.
- `lft_rev`, out, 1: left reverse.
- `rght_spd`, out, 11: right magnitude.
- `rght_rev`, out, 1: right reverse.
- `at_tgt`, out, 1: both channels are in RUN with commanded speed equal to target.

## Operation
- **Target capture.** Target registers (12-bit signed, reset 0) load on any clock with `tgt_vld`=1. Otherwise they hold.
- **Frame counter.** Counts 0..`UPD_PERIOD`-1 and then wraps to 0. `tick`=1 while the count equals `UPD_PERIOD`-1. Both channels update only on `tick`.
- **Per-channel state.** 12-bit signed `cur` (reset 0), state RUN/DWELL (reset RUN), and an 8-bit dwell counter (reset 0).
- **RUN on tick, general case.** If `cur`≠`tgt`, `cur` moves toward `tgt` by min(`STEP`, |`tgt`−`cur`|). The difference is computed at 13 bits, so there is no overflow.
- **RUN on tick, reversal case (dwell enabled).** Applies when `cur`≠0, `tgt` has the opposite strict sign, and the step would reach or cross zero:
  - `cur` is set to 0.
  - The channel enters DWELL.
  - The dwell counter loads `DWELL_FRAMES`.
- **DWELL on tick.**
  - `cur` holds at 0 and the dwell counter decrements.
  - When the counter reaches 0, the channel returns to RUN; no step is taken on that tick.
  - Target changes during DWELL do not shorten it.
- **Output mapping.**
  - `rev` = sign of `cur`.
  - `spd` = |`cur`|, saturated to 2047. `cur`=−2048 gives `spd`=2047, `rev`=1.
- **`at_tgt`.** AND over both channels of (state==RUN && `cur`==`tgt`).
- **Simultaneous `tgt_vld` and `tick`.** The tick step uses the previously held target. The new target takes effect from the next tick.

## Timing
- All outputs are registered. They change only on the clock edge that ends a tick cycle, so they are constant across a PWM frame.
- The first tick completes at the `UPD_PERIOD`-th rising edge after `rst_n` deasserts.
- **Latency.** A target captured at edge N affects outputs no earlier than the next tick edge after N.
- **Reset values.** `lft_spd`=`rght_spd`=0, `lft_rev`=`rght_rev`=0, `at_tgt`=1 (cur=tgt=0, RUN).
- **Reset mid-operation.** Asynchronous assertion immediately forces all of the following to their reset values:
  - outputs
  - `cur`
  - targets
  - state
  - frame counter
  - dwell counter

## Configuration
- `ZERO_DWELL_EN` defined: the DWELL state and the reversal rule are present, as described above.
- `ZERO_DWELL_EN` undefined:
  - There is no DWELL state, and the dwell counter and `DWELL_FRAMES` are unused.
  - `cur` steps straight through zero with the general RUN rule.
  - `at_tgt` reduces to `cur`==`tgt` for both channels.

## Structure
- **Package `spd_ramp_pkg`** contains:
  - the state enum `ramp_state_t` {RUN, DWELL}
  - `SPD_W`=11 and `TGT_W`=12
  - the saturation constant `SPD_MAX`=11'h7FF
- **Sub-module `spd_ramp_chan`** is one per wheel and holds the target, `cur`, state, dwell counter and output mapping.
- **Top** instantiates two channels plus a shared frame counter and the `at_tgt` AND.

## Test plan
Bench uses `STEP`=16, `UPD_PERIOD`=8, `DWELL_FRAMES`=4.
- **Reset.** Hold `rst_n`=0, then release → all `spd`/`rev`=0, `at_tgt`=1; first output change possible only at the 8th edge.
- **Ramp up.** `lft_tgt`=+100 → `lft_spd` per tick 16, 32, 48, 64, 80, 96, 100, `lft_rev`=0; `at_tgt` rises with the 100 update; right channel stays 0.
- **Reversal with dwell (macro defined).** `cur`=+40, new target −40 → `spd` sequence 24, 8, 0, then 0 for 4 more ticks, then 16 `rev`=1, 32, 40; `at_tgt`=0 throughout the dwell.
- **Reversal without macro.** Same stimulus → 24/`rev`0, 8/`rev`0, 8/`rev`1, 24/`rev`1, 40/`rev`1.
- **Saturation.** `rght_tgt`=−2048 with `STEP`=2047 → after 2 ticks `rght_spd`=2047, `rght_rev`=1, `at_tgt`=1.
- **Async reset mid-ramp.** Assert `rst_n`=0 while `lft_spd`=64 between ticks → outputs 0 immediately without a clock; after release, ramping restarts from 0.

Source files
------------

// File: rtl/spd_ramp_pkg.sv
// Shared types and constants for the spd_ramp slew limiter.
// Build option: ZERO_DWELL_EN enables the zero-speed dwell before reversals.
package spd_ramp_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DWELL = 1'b1
   } ramp_state_t;

   localparam int SPD_W = 11;
   localparam int TGT_W = 12;

   localparam logic [SPD_W-1:0] SPD_MAX = 11'h7FF;

   // Per-channel debug view of the ramp state machine.
   typedef struct packed {
      ramp_state_t state;
      logic [7:0]  dwell_cnt;
   } chan_dbg_t;

   // Magnitude of a signed command, clipped to the driver's 11-bit range.
   function automatic logic [SPD_W-1:0] sat_mag(input logic [TGT_W-1:0] v);
      logic [TGT_W:0] ext;
      logic [TGT_W:0] m;
      ext = {v[TGT_W-1], v};
      m   = v[TGT_W-1] ? (~ext + 13'd1) : ext;
      return (m > {2'b00, SPD_MAX}) ? SPD_MAX : m[SPD_W-1:0];
   endfunction

endpackage

// File: rtl/spd_ramp_chan.sv
// One wheel: target register, ramped command, optional reversal dwell,
// and sign/magnitude output mapping. Everything updates only on tick,
// except the target register which loads whenever tgt_vld is high.
// Build option: ZERO_DWELL_EN adds the reversal dwell behaviour.
module spd_ramp_chan
   import spd_ramp_pkg::*;
#(
   parameter int STEP         = 16,
   parameter int DWELL_FRAMES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             tgt_vld,
   input  logic [TGT_W-1:0] tgt_val,
   output logic [SPD_W-1:0] spd,
   output logic             rev,
   output logic             match,
   output chan_dbg_t        dbg
);

   logic signed [TGT_W-1:0] tgt;
   logic signed [TGT_W-1:0] cur;
   logic signed [TGT_W-1:0] cur_n;
   logic [7:0]              dwell_cnt;
   logic [7:0]              dwell_cnt_n;
   ramp_state_t             state;
   ramp_state_t             state_n;

   logic [TGT_W:0]          diff;
   logic [TGT_W:0]          mag;
   logic [TGT_W:0]          step_amt;
   logic [TGT_W:0]          stepped;
   logic [TGT_W-1:0]        cur_step;
   logic                    rev_hit;

   // Target register: loads on any valid, independent of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tgt <= '0;
      else if (tgt_vld) tgt <= tgt_val;
   end

   // Step toward target by min(STEP, |tgt-cur|), computed at 13 bits.
   always_comb begin
      diff     = {tgt[TGT_W-1], tgt} - {cur[TGT_W-1], cur};
      mag      = diff[TGT_W] ? (~diff + 13'd1) : diff;
      step_amt = (mag < 13'(STEP)) ? mag : 13'(STEP);
      stepped  = diff[TGT_W] ? ({cur[TGT_W-1], cur} - step_amt)
                             : ({cur[TGT_W-1], cur} + step_amt);
      cur_step = stepped[TGT_W-1:0];
   end

`ifdef ZERO_DWELL_EN
   // Reversal: opposite strict signs and the step lands on or past zero.
   always_comb begin
      rev_hit = (cur != '0) && (tgt != '0) && (tgt[TGT_W-1] != cur[TGT_W-1]) &&
                ((cur_step == '0) || (cur_step[TGT_W-1] != cur[TGT_W-1]));
   end
`else
   // Without the dwell the command ramps straight through zero.
   always_comb begin
      rev_hit = 1'b0;
   end
`endif

   // Next-state logic for the RUN/DWELL machine and the command.
   always_comb begin
      state_n     = state;
      cur_n       = cur;
      dwell_cnt_n = dwell_cnt;
      if (tick) begin
         case (state)
            RUN: begin
               if (rev_hit) begin
                  cur_n       = '0;
                  state_n     = DWELL;
                  dwell_cnt_n = 8'(DWELL_FRAMES);
               end else begin
                  cur_n = cur_step;
               end
            end
            DWELL: begin
               cur_n       = '0;
               dwell_cnt_n = dwell_cnt - 8'd1;
               if (dwell_cnt == 8'd1) state_n = RUN;
            end
            default: state_n = RUN;
         endcase
      end
   end

   // State, command and registered outputs; the match flag compares
   // against the target that was used for this tick's step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         cur       <= '0;
         dwell_cnt <= '0;
         spd       <= '0;
         rev       <= 1'b0;
         match     <= 1'b1;
      end else begin
         state     <= state_n;
         cur       <= cur_n;
         dwell_cnt <= dwell_cnt_n;
         if (tick) begin
            spd   <= sat_mag(cur_n);
            rev   <= cur_n[TGT_W-1];
            match <= (state_n == RUN) && (cur_n == tgt);
         end
      end
   end

   assign dbg.state     = state;
   assign dbg.dwell_cnt = dwell_cnt;

endmodule

// File: rtl/spd_ramp.sv
// Two-wheel slew-rate limiter: shared PWM-frame tick, one ramp channel
// per wheel, and the combined at-target flag.
// Build option: ZERO_DWELL_EN enables the zero-speed dwell before reversals.
module spd_ramp
   import spd_ramp_pkg::*;
#(
   parameter int STEP         = 16,
   parameter int UPD_PERIOD   = 2048,
   parameter int DWELL_FRAMES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [TGT_W-1:0] lft_tgt,
   input  logic [TGT_W-1:0] rght_tgt,
   input  logic             tgt_vld,
   output logic [SPD_W-1:0] lft_spd,
   output logic             lft_rev,
   output logic [SPD_W-1:0] rght_spd,
   output logic             rght_rev,
   output logic             at_tgt,
   output chan_dbg_t        lft_dbg,
   output chan_dbg_t        rght_dbg
);

   localparam int CNT_W = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(UPD_PERIOD - 1);

   logic [CNT_W-1:0] frm_cnt;
   logic             tick;
   logic             lft_match;
   logic             rght_match;

   assign tick = (frm_cnt == LAST);

   // Frame counter: 0..UPD_PERIOD-1, tick on the last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    frm_cnt <= '0;
      else if (tick) frm_cnt <= '0;
      else           frm_cnt <= frm_cnt + 1'b1;
   end

   spd_ramp_chan #(.STEP(STEP), .DWELL_FRAMES(DWELL_FRAMES)) u_lft (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .tgt_vld (tgt_vld),
      .tgt_val (lft_tgt),
      .spd     (lft_spd),
      .rev     (lft_rev),
      .match   (lft_match),
      .dbg     (lft_dbg)
   );

   spd_ramp_chan #(.STEP(STEP), .DWELL_FRAMES(DWELL_FRAMES)) u_rght (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .tgt_vld (tgt_vld),
      .tgt_val (rght_tgt),
      .spd     (rght_spd),
      .rev     (rght_rev),
      .match   (rght_match),
      .dbg     (rght_dbg)
   );

   assign at_tgt = lft_match & rght_match;

endmodule

// File: tb/tb_spd_ramp.sv
// Self-checking bench for spd_ramp: STEP=16, UPD_PERIOD=8, DWELL_FRAMES=4,
// plus a second instance with STEP=2047 for the saturation case.
// Expected outputs per tick are queued as {lspd,lrev,rspd,rrev,at_tgt}.
module tb_spd_ramp;
   import spd_ramp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] lft_tgt = '0, rght_tgt = '0;
   logic        tgt_vld = 1'b0;
   logic [10:0] lft_spd, rght_spd;
   logic        lft_rev, rght_rev, at_tgt;
   chan_dbg_t   lft_dbg, rght_dbg;

   logic [11:0] s_lft_tgt = '0, s_rght_tgt = '0;
   logic        s_tgt_vld = 1'b0;
   logic [10:0] s_lft_spd, s_rght_spd;
   logic        s_lft_rev, s_rght_rev, s_at_tgt;
   chan_dbg_t   s_lft_dbg, s_rght_dbg;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [24:0] exp_q[$];
   logic [24:0] exp_v;
   logic [24:0] obs;

   spd_ramp #(.STEP(16), .UPD_PERIOD(8), .DWELL_FRAMES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .lft_tgt(lft_tgt), .rght_tgt(rght_tgt),
      .tgt_vld(tgt_vld), .lft_spd(lft_spd), .lft_rev(lft_rev),
      .rght_spd(rght_spd), .rght_rev(rght_rev), .at_tgt(at_tgt),
      .lft_dbg(lft_dbg), .rght_dbg(rght_dbg)
   );

   spd_ramp #(.STEP(2047), .UPD_PERIOD(8), .DWELL_FRAMES(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .lft_tgt(s_lft_tgt), .rght_tgt(s_rght_tgt),
      .tgt_vld(s_tgt_vld), .lft_spd(s_lft_spd), .lft_rev(s_lft_rev),
      .rght_spd(s_rght_spd), .rght_rev(s_rght_rev), .at_tgt(s_at_tgt),
      .lft_dbg(s_lft_dbg), .rght_dbg(s_rght_dbg)
   );

   // Clock and reset-relative edge counter (tick edges are multiples of 8).
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [24:0] pk(int ls, bit lr, int rs, bit rr, bit at);
      return {11'(ls), lr, 11'(rs), rr, at};
   endfunction

   function automatic logic [24:0] dut_obs();
      return {lft_spd, lft_rev, rght_spd, rght_rev, at_tgt};
   endfunction

   function automatic logic [24:0] sat_obs();
      return {s_lft_spd, s_lft_rev, s_rght_spd, s_rght_rev, s_at_tgt};
   endfunction

   // Advance to the next tick edge, sampling 1ns after it.
   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((cyc % 8 != 0) && (n < 20));
      if (cyc % 8 != 0) begin
         errors++;
         $display("FAIL tick_timeout: cyc=%0d expected a multiple of 8", cyc);
      end
   endtask

   task automatic set_tgt(input logic [11:0] l, input logic [11:0] r);
      @(negedge clk);
      lft_tgt  = l;
      rght_tgt = r;
      tgt_vld  = 1'b1;
      @(negedge clk);
      tgt_vld  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dut_obs() !== pk(0, 0, 0, 0, 1)) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", dut_obs(), pk(0, 0, 0, 0, 1));
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (sat_obs() !== pk(0, 0, 0, 0, 1)) begin
         errors++;
         $display("FAIL reset_release_sat: got %h expected %h", sat_obs(), pk(0, 0, 0, 0, 1));
      end
   endtask

   task automatic test_ramp_up();
      set_tgt(12'sd100, 12'sd0);
      while (cyc < 7) begin
         @(posedge clk); #1;
      end
      checks++;
      if (dut_obs() !== pk(0, 0, 0, 0, 1)) begin
         errors++;
         $display("FAIL ramp_hold_frame: got %h expected %h", dut_obs(), pk(0, 0, 0, 0, 1));
      end
      for (int i = 1; i <= 6; i++) exp_q.push_back(pk(16 * i, 0, 0, 0, 0));
      exp_q.push_back(pk(100, 0, 0, 0, 1));
      while (exp_q.size() > 0) begin
         wait_tick();
         exp_v = exp_q.pop_front();
         obs = dut_obs();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL ramp_tick: got %h expected %h", obs, exp_v);
         end
      end
   endtask

   task automatic test_reversal();
      set_tgt(12'sd40, 12'sd0);
      exp_q.push_back(pk(84, 0, 0, 0, 0));
      exp_q.push_back(pk(68, 0, 0, 0, 0));
      exp_q.push_back(pk(52, 0, 0, 0, 0));
      exp_q.push_back(pk(40, 0, 0, 0, 1));
      while (exp_q.size() > 0) begin
         wait_tick();
         exp_v = exp_q.pop_front();
         obs = dut_obs();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL down_tick: got %h expected %h", obs, exp_v);
         end
      end
      set_tgt(-12'sd40, 12'sd0);
      exp_q.push_back(pk(24, 0, 0, 0, 0));
      exp_q.push_back(pk(8, 0, 0, 0, 0));
`ifdef ZERO_DWELL_EN
      for (int i = 0; i < 5; i++) exp_q.push_back(pk(0, 0, 0, 0, 0));
      exp_q.push_back(pk(16, 1, 0, 0, 0));
      exp_q.push_back(pk(32, 1, 0, 0, 0));
      exp_q.push_back(pk(40, 1, 0, 0, 1));
`else
      exp_q.push_back(pk(8, 1, 0, 0, 0));
      exp_q.push_back(pk(24, 1, 0, 0, 0));
      exp_q.push_back(pk(40, 1, 0, 0, 1));
`endif
      while (exp_q.size() > 0) begin
         wait_tick();
         exp_v = exp_q.pop_front();
         obs = dut_obs();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL reversal_tick: got %h expected %h", obs, exp_v);
         end
      end
   endtask

   task automatic test_collision();
      // Capture a new right target on the tick edge itself.
      while (cyc % 8 != 7) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      rght_tgt = 12'sd32;
      tgt_vld  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut_obs() !== pk(40, 1, 0, 0, 1)) begin
         errors++;
         $display("FAIL collision_tick: got %h expected %h", dut_obs(), pk(40, 1, 0, 0, 1));
      end
      @(negedge clk);
      tgt_vld = 1'b0;
      exp_q.push_back(pk(40, 1, 16, 0, 0));
      exp_q.push_back(pk(40, 1, 32, 0, 1));
      while (exp_q.size() > 0) begin
         wait_tick();
         exp_v = exp_q.pop_front();
         obs = dut_obs();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL collision_after: got %h expected %h", obs, exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      s_rght_tgt = 12'h800;
      s_tgt_vld  = 1'b1;
      @(negedge clk);
      s_tgt_vld  = 1'b0;
      exp_q.push_back(pk(0, 0, 2047, 1, 0));
      exp_q.push_back(pk(0, 0, 2047, 1, 1));
      while (exp_q.size() > 0) begin
         wait_tick();
         exp_v = exp_q.pop_front();
         obs = sat_obs();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL saturation_tick: got %h expected %h", obs, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_tgt(12'sd100, 12'sd0);
      for (int i = 1; i <= 4; i++) exp_q.push_back(pk(16 * i, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         wait_tick();
         exp_v = exp_q.pop_front();
         obs = dut_obs();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_tick: got %h expected %h", obs, exp_v);
         end
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_obs() !== pk(0, 0, 0, 0, 1)) begin
         errors++;
         $display("FAIL async_reset_out: got %h expected %h", dut_obs(), pk(0, 0, 0, 0, 1));
      end
      checks++;
      if (sat_obs() !== pk(0, 0, 0, 0, 1)) begin
         errors++;
         $display("FAIL async_reset_sat: got %h expected %h", sat_obs(), pk(0, 0, 0, 0, 1));
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // Targets were cleared, so the first tick keeps everything at zero.
      wait_tick();
      checks++;
      if (dut_obs() !== pk(0, 0, 0, 0, 1)) begin
         errors++;
         $display("FAIL async_tgt_cleared: got %h expected %h", dut_obs(), pk(0, 0, 0, 0, 1));
      end
      set_tgt(12'sd100, 12'sd0);
      exp_q.push_back(pk(16, 0, 0, 0, 0));
      exp_q.push_back(pk(32, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         wait_tick();
         exp_v = exp_q.pop_front();
         obs = dut_obs();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL restart_tick: got %h expected %h", obs, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_reversal();
      test_collision();
      test_saturation();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL time_limit: simulation exceeded 200000 time units");
      $fatal(1);
   end

endmodule
